// File: rtl/brq_dmem_arbiter.sv
// Round-robin N-master arbiter in front of the single-port DCCM, with 1-cycle read-data return.
// Optional BRQ_ARB_LOCK_EN adds m_lock so one master can hold the DCCM across an atomic sequence.
module brq_dmem_arbiter #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 15,
    parameter int NUM_MASTERS = 2,
    parameter int MIDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic                             brq_clk,
    input  logic                             brq_rst,
    input  logic [NUM_MASTERS-1:0]           m_req,
    input  logic [NUM_MASTERS-1:0]           m_we,
    input  logic [NUM_MASTERS*AddrWidth-1:0] m_addr,
    input  logic [NUM_MASTERS*DataWidth-1:0] m_wdata,
    input  logic [NUM_MASTERS*3-1:0]         m_byte_en,
`ifdef BRQ_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]           m_lock,
`endif
    output logic [NUM_MASTERS-1:0]           m_gnt,
    output logic [NUM_MASTERS-1:0]           m_rvalid,
    output logic [DataWidth-1:0]             m_rdata,
    output logic                             mem_read_en,
    output logic                             mem_write_en,
    output logic [AddrWidth-1:0]             mem_addr,
    output logic [DataWidth-1:0]             mem_wdata,
    output logic [2:0]                       mem_byte_en,
    input  logic [DataWidth-1:0]             mem_rdata
);

    // Handshake: a master holds m_req and its payload stable until it sees m_gnt;
    // the access completes in the grant cycle, and reads return on m_rvalid one cycle later.

    logic [MIDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] rd_pend_q, rd_pend_d;
    logic [NUM_MASTERS-1:0] elig;
    logic                   gnt_found;
    logic [MIDX_W-1:0]      gnt_idx;

`ifdef BRQ_ARB_LOCK_EN
    logic              lock_q, lock_d;
    logic [MIDX_W-1:0] lock_owner_q, lock_owner_d;

    always_comb begin
        elig = m_req;
        if (lock_q) begin
            elig = '0;
            elig[lock_owner_q] = m_req[lock_owner_q];
        end
    end
`else
    assign elig = m_req;
`endif

    // Lowest eligible index at or above rr_ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = MIDX_W'(i);
            end
        end
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (elig[i] && (MIDX_W'(i) >= rr_ptr_q)) begin
                gnt_idx = MIDX_W'(i);
            end
        end
    end

    always_comb begin
        m_gnt        = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_byte_en  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_found && (gnt_idx == MIDX_W'(i))) begin
                m_gnt[i]     = 1'b1;
                mem_write_en = m_we[i];
                mem_read_en  = ~m_we[i];
                mem_addr     = m_addr[i*AddrWidth +: AddrWidth];
                mem_wdata    = m_wdata[i*DataWidth +: DataWidth];
                mem_byte_en  = m_byte_en[i*3 +: 3];
            end
        end
    end

    always_comb begin
        rd_pend_d = m_gnt & ~m_we;
        rr_ptr_d  = rr_ptr_q;
`ifdef BRQ_ARB_LOCK_EN
        if (gnt_found && !lock_q) begin
`else
        if (gnt_found) begin
`endif
            rr_ptr_d = (gnt_idx == MIDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + MIDX_W'(1);
        end
    end

`ifdef BRQ_ARB_LOCK_EN
    // Lock drops when the owner releases m_req or completes an unlocked access.
    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (lock_q) begin
            if (!m_req[lock_owner_q]) begin
                lock_d = 1'b0;
            end else if (m_gnt[lock_owner_q] && !m_lock[lock_owner_q]) begin
                lock_d = 1'b0;
            end
        end else if (gnt_found && m_lock[gnt_idx]) begin
            lock_d       = 1'b1;
            lock_owner_d = gnt_idx;
        end
    end

    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst) begin
            lock_q       <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`endif

    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst) begin
            rr_ptr_q  <= '0;
            rd_pend_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign m_rvalid = rd_pend_q;
    assign m_rdata  = mem_rdata;

endmodule

// File: tb/tb_brq_dmem_arbiter.sv
// Directed bench for brq_dmem_arbiter: a 2-master instance backed by a DCCM model,
// plus a 3-master instance for round-robin contention.
module tb_brq_dmem_arbiter;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    // 2-master instance signals
    logic [1:0]  a_req, a_we, a_lock;
    logic [29:0] a_addr;
    logic [63:0] a_wdata;
    logic [5:0]  a_be;
    logic [1:0]  a_gnt, a_rvalid;
    logic [31:0] a_rdata, a_mem_wdata, a_mem_rdata;
    logic        a_rd_en, a_wr_en;
    logic [14:0] a_mem_addr;
    logic [2:0]  a_mem_be;

    // 3-master instance signals
    logic [2:0]  b_req, b_we, b_lock;
    logic [44:0] b_addr;
    logic [95:0] b_wdata;
    logic [8:0]  b_be;
    logic [2:0]  b_gnt, b_rvalid;
    logic [31:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_rd_en, b_wr_en;
    logic [14:0] b_mem_addr;
    logic [2:0]  b_mem_be;

    logic [31:0] dccm [0:255];

    brq_dmem_arbiter #(.DataWidth(32), .AddrWidth(15), .NUM_MASTERS(2)) u_dut2 (
        .brq_clk(clk), .brq_rst(rst),
        .m_req(a_req), .m_we(a_we), .m_addr(a_addr), .m_wdata(a_wdata), .m_byte_en(a_be),
`ifdef BRQ_ARB_LOCK_EN
        .m_lock(a_lock),
`endif
        .m_gnt(a_gnt), .m_rvalid(a_rvalid), .m_rdata(a_rdata),
        .mem_read_en(a_rd_en), .mem_write_en(a_wr_en), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_byte_en(a_mem_be), .mem_rdata(a_mem_rdata)
    );

    brq_dmem_arbiter #(.DataWidth(32), .AddrWidth(15), .NUM_MASTERS(3)) u_dut3 (
        .brq_clk(clk), .brq_rst(rst),
        .m_req(b_req), .m_we(b_we), .m_addr(b_addr), .m_wdata(b_wdata), .m_byte_en(b_be),
`ifdef BRQ_ARB_LOCK_EN
        .m_lock(b_lock),
`endif
        .m_gnt(b_gnt), .m_rvalid(b_rvalid), .m_rdata(b_rdata),
        .mem_read_en(b_rd_en), .mem_write_en(b_wr_en), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_byte_en(b_mem_be), .mem_rdata(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port DCCM model with 1-cycle read latency
    always @(posedge clk) begin
        if (a_wr_en) dccm[a_mem_addr[7:0]] <= a_mem_wdata;
        if (a_rd_en) a_mem_rdata <= dccm[a_mem_addr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int i, input logic req, input logic we, input logic [14:0] addr,
                           input logic [31:0] wdata, input logic [2:0] be, input logic lock);
        a_req[i]            = req;
        a_we[i]             = we;
        a_addr[i*15 +: 15]  = addr;
        a_wdata[i*32 +: 32] = wdata;
        a_be[i*3 +: 3]      = be;
        a_lock[i]           = lock;
    endtask

    task automatic idle_a();
        a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0; a_lock = '0;
    endtask

    task automatic test_reset();
        drive_a(0, 1'b0, 1'b1, 15'h1234, 32'hFFFF_FFFF, 3'b111, 1'b0);
        #1;
        n_total++; if (a_gnt !== 2'b00) $display("FAIL rst_gnt: got %b want 00", a_gnt); else n_pass++;
        n_total++; if (a_rvalid !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", a_rvalid); else n_pass++;
        n_total++; if (a_rd_en !== 1'b0 || a_wr_en !== 1'b0) $display("FAIL rst_en: got rd=%b wr=%b want 0 0", a_rd_en, a_wr_en); else n_pass++;
        n_total++; if (a_mem_addr !== 15'h0) $display("FAIL idle_addr: got %h want 0000", a_mem_addr); else n_pass++;
        n_total++; if (a_mem_wdata !== 32'h0 || a_mem_be !== 3'b000) $display("FAIL idle_wdata_be: got %h %b want 0 000", a_mem_wdata, a_mem_be); else n_pass++;
        n_total++; if (b_gnt !== 3'b000 || b_rvalid !== 3'b000) $display("FAIL rst_b: got gnt=%b rvalid=%b want 000 000", b_gnt, b_rvalid); else n_pass++;
        idle_a();
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive_a(0, 1'b1, 1'b0, 15'h010, 32'h0, 3'b010, 1'b0);
        @(negedge clk);
        n_total++; if (a_gnt !== 2'b01 || a_rd_en !== 1'b1) $display("FAIL midrd_gnt: got gnt=%b rd=%b want 01 1", a_gnt, a_rd_en); else n_pass++;
        n_total++; if (a_mem_addr !== 15'h010) $display("FAIL midrd_addr: got %h want 0010", a_mem_addr); else n_pass++;
        tick();
        idle_a();
        rst = 1'b1;
        #1;
        n_total++; if (a_rvalid !== 2'b00) $display("FAIL midrd_rvalid: got %b want 00", a_rvalid); else n_pass++;
        n_total++; if (a_rd_en !== 1'b0 || a_wr_en !== 1'b0) $display("FAIL midrd_en: got rd=%b wr=%b want 0 0", a_rd_en, a_wr_en); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_a(0, 1'b1, 1'b0, 15'h010, 32'h0, 3'b010, 1'b0);
        drive_a(1, 1'b1, 1'b0, 15'h014, 32'h0, 3'b010, 1'b0);
        #1;
        n_total++; if (a_gnt !== 2'b01) $display("FAIL ptr_after_rst: got %b want 01", a_gnt); else n_pass++;
        tick();
        n_total++; if (a_rvalid !== 2'b01) $display("FAIL rr_rvalid0: got %b want 01", a_rvalid); else n_pass++;
        n_total++; if (a_gnt !== 2'b10) $display("FAIL rr_second: got %b want 10", a_gnt); else n_pass++;
        drive_a(0, 1'b0, 1'b0, 15'h0, 32'h0, 3'b000, 1'b0);
        tick();
        idle_a();
        n_total++; if (a_rvalid !== 2'b10) $display("FAIL rr_rvalid1: got %b want 10", a_rvalid); else n_pass++;
    endtask

    task automatic test_write();
        drive_a(0, 1'b1, 1'b1, 15'h008, 32'h1234_5678, 3'b010, 1'b0);
        @(negedge clk);
        n_total++; if (a_gnt !== 2'b01) $display("FAIL wr_gnt: got %b want 01", a_gnt); else n_pass++;
        n_total++; if (a_wr_en !== 1'b1 || a_rd_en !== 1'b0) $display("FAIL wr_en: got wr=%b rd=%b want 1 0", a_wr_en, a_rd_en); else n_pass++;
        n_total++; if (a_mem_wdata !== 32'h1234_5678) $display("FAIL wr_wdata: got %h want 12345678", a_mem_wdata); else n_pass++;
        n_total++; if (a_mem_be !== 3'b010 || a_mem_addr !== 15'h008) $display("FAIL wr_be_addr: got %b %h want 010 0008", a_mem_be, a_mem_addr); else n_pass++;
        tick();
        idle_a();
        n_total++; if (a_rvalid !== 2'b00) $display("FAIL wr_no_rvalid: got %b want 00", a_rvalid); else n_pass++;
        drive_a(0, 1'b1, 1'b0, 15'h008, 32'h0, 3'b010, 1'b0);
        @(negedge clk);
        n_total++; if (a_gnt !== 2'b01 || a_rd_en !== 1'b1) $display("FAIL rdback_gnt: got gnt=%b rd=%b want 01 1", a_gnt, a_rd_en); else n_pass++;
        tick();
        idle_a();
        n_total++; if (a_rvalid !== 2'b01) $display("FAIL rdback_rvalid: got %b want 01", a_rvalid); else n_pass++;
        n_total++; if (a_rdata !== 32'h1234_5678) $display("FAIL rdback_data: got %h want 12345678", a_rdata); else n_pass++;
    endtask

    task automatic test_single_read();
        drive_a(0, 1'b1, 1'b1, 15'h004, 32'hDEAD_BEEF, 3'b010, 1'b0);
        tick();
        idle_a();
        drive_a(1, 1'b1, 1'b0, 15'h004, 32'h0, 3'b010, 1'b0);
        @(negedge clk);
        n_total++; if (a_gnt !== 2'b10) $display("FAIL rd1_gnt: got %b want 10", a_gnt); else n_pass++;
        n_total++; if (a_rd_en !== 1'b1 || a_wr_en !== 1'b0) $display("FAIL rd1_en: got rd=%b wr=%b want 1 0", a_rd_en, a_wr_en); else n_pass++;
        n_total++; if (a_mem_addr !== 15'h004) $display("FAIL rd1_addr: got %h want 0004", a_mem_addr); else n_pass++;
        tick();
        idle_a();
        n_total++; if (a_rvalid !== 2'b10) $display("FAIL rd1_rvalid: got %b want 10", a_rvalid); else n_pass++;
        n_total++; if (a_rdata !== 32'hDEAD_BEEF) $display("FAIL rd1_data: got %h want deadbeef", a_rdata); else n_pass++;
        tick();
        n_total++; if (a_rvalid !== 2'b00) $display("FAIL rd1_rvalid_drop: got %b want 00", a_rvalid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive_a(0, 1'b1, 1'b1, 15'h000, 32'hA5A5_0000, 3'b010, 1'b0);
        tick();
        drive_a(0, 1'b1, 1'b0, 15'h000, 32'h0, 3'b010, 1'b0);
        @(negedge clk);
        n_total++; if (a_gnt !== 2'b01) $display("FAIL b2b_gnt0: got %b want 01", a_gnt); else n_pass++;
        tick();
        drive_a(0, 1'b0, 1'b0, 15'h0, 32'h0, 3'b000, 1'b0);
        drive_a(1, 1'b1, 1'b0, 15'h004, 32'h0, 3'b010, 1'b0);
        n_total++; if (a_rvalid !== 2'b01) $display("FAIL b2b_rvalid0: got %b want 01", a_rvalid); else n_pass++;
        n_total++; if (a_rdata !== 32'hA5A5_0000) $display("FAIL b2b_data0: got %h want a5a50000", a_rdata); else n_pass++;
        @(negedge clk);
        n_total++; if (a_gnt !== 2'b10) $display("FAIL b2b_gnt1: got %b want 10", a_gnt); else n_pass++;
        tick();
        idle_a();
        n_total++; if (a_rvalid !== 2'b10) $display("FAIL b2b_rvalid1: got %b want 10", a_rvalid); else n_pass++;
        n_total++; if (a_rdata !== 32'hDEAD_BEEF) $display("FAIL b2b_data1: got %h want deadbeef", a_rdata); else n_pass++;
    endtask

    task automatic test_contention();
        logic [2:0] exp_gnt;
        logic [2:0] prev_gnt;
        prev_gnt = 3'b000;
        b_req    = 3'b111;
        b_we     = 3'b000;
        b_addr   = {15'h030, 15'h020, 15'h010};
        for (int c = 0; c < 6; c++) begin
            exp_gnt = 3'b001 << (c % 3);
            @(negedge clk);
            n_total++; if (b_gnt !== exp_gnt) $display("FAIL rr3_gnt c%0d: got %b want %b", c, b_gnt, exp_gnt); else n_pass++;
            n_total++; if (b_mem_addr !== 15'((c % 3 + 1) * 16)) $display("FAIL rr3_addr c%0d: got %h want %h", c, b_mem_addr, 15'((c % 3 + 1) * 16)); else n_pass++;
            n_total++; if (b_rvalid !== prev_gnt) $display("FAIL rr3_rvalid c%0d: got %b want %b", c, b_rvalid, prev_gnt); else n_pass++;
            prev_gnt = exp_gnt;
            tick();
        end
        b_req = 3'b000;
        n_total++; if (b_rvalid !== 3'b100) $display("FAIL rr3_last_rvalid: got %b want 100", b_rvalid); else n_pass++;
        n_total++; if (b_rdata !== 32'h0BAD_F00D) $display("FAIL rr3_rdata: got %h want 0badf00d", b_rdata); else n_pass++;
        tick();
    endtask

`ifdef BRQ_ARB_LOCK_EN
    task automatic test_lock();
        drive_a(0, 1'b1, 1'b0, 15'h008, 32'h0, 3'b010, 1'b1);
        drive_a(1, 1'b1, 1'b0, 15'h004, 32'h0, 3'b010, 1'b0);
        @(negedge clk);
        n_total++; if (a_gnt !== 2'b01) $display("FAIL lock_gnt0: got %b want 01", a_gnt); else n_pass++;
        tick();
        drive_a(0, 1'b1, 1'b1, 15'h008, 32'h1234_5679, 3'b010, 1'b0);
        @(negedge clk);
        n_total++; if (a_gnt !== 2'b01) $display("FAIL lock_hold: got %b want 01", a_gnt); else n_pass++;
        n_total++; if (a_rvalid !== 2'b01) $display("FAIL lock_rvalid: got %b want 01", a_rvalid); else n_pass++;
        tick();
        drive_a(0, 1'b0, 1'b0, 15'h0, 32'h0, 3'b000, 1'b0);
        @(negedge clk);
        n_total++; if (a_gnt !== 2'b10) $display("FAIL lock_release: got %b want 10", a_gnt); else n_pass++;
        tick();
        idle_a();
        n_total++; if (a_rdata !== 32'hDEAD_BEEF || a_rvalid !== 2'b10) $display("FAIL lock_m1_data: got %h %b want deadbeef 10", a_rdata, a_rvalid); else n_pass++;
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        idle_a();
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0; b_lock = '0;
        b_mem_rdata = 32'h0BAD_F00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        test_reset();
        test_reset_mid_read();
        test_write();
        test_single_read();
        test_back_to_back();
        test_contention();
`ifdef BRQ_ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/brq_dmem_arbiter.md
Name: brq_dmem_arbiter

Overview:
- Parametrised N-master arbiter in front of the single-port DCCM, so the core and additional masters (loader, debug, DMA) can share data memory.
- Round-robin grant; each granted access is issued to the DCCM in the same cycle.
- Read data is routed back to the granted master one cycle later, matching the DCCM's 1-cycle read latency.
- Sits between the core's data port and DCCM at SoC top level.

Parameters:
- DataWidth, 32, data bus width.
- AddrWidth, 15, word/byte address width passed to DCCM.
- NUM_MASTERS, 2, number of requesting masters (>=2, <=8).
- MIDX_W, $clog2(NUM_MASTERS), master index width (derived, do not override).

Ports:
- brq_clk  in  1  clock; all state on rising edge.
- brq_rst  in  1  reset, asynchronous, active-high.
- m_req  in  NUM_MASTERS  per-master access request.
- m_we  in  NUM_MASTERS  per-master write (1) / read (0).
- m_addr  in  NUM_MASTERS*AddrWidth  packed addresses, master i at [i*AddrWidth +: AddrWidth].
- m_wdata  in  NUM_MASTERS*DataWidth  packed write data.
- m_byte_en  in  NUM_MASTERS*3  packed load/store size codes (DCCM funct3 encoding).
- m_gnt  out  NUM_MASTERS  one-hot grant, combinational, same cycle as request.
- m_rvalid  out  NUM_MASTERS  one-hot read-data-valid, 1 cycle after a read grant.
- m_rdata  out  DataWidth  read data, shared; qualify with m_rvalid.
- mem_read_en  out  1  DCCM read enable.
- mem_write_en  out  1  DCCM write enable.
- mem_addr  out  AddrWidth  DCCM address.
- mem_wdata  out  DataWidth  DCCM write data.
- mem_byte_en  out  3  DCCM size code.
- mem_rdata  in  DataWidth  DCCM read data, valid 1 cycle after mem_read_en.

Behaviour:
- State:
  - rr_ptr (MIDX_W): highest-priority master.
  - rd_pend_q (NUM_MASTERS): one-hot read-in-flight tag.
- Reset (async): rr_ptr=0, rd_pend_q=0. Hence m_rvalid=0. With no request, m_gnt=0, mem_read_en=0, mem_write_en=0, mem_addr=0, mem_wdata=0, mem_byte_en=0.
- Arbitration (combinational):
  - Search m_req starting at index rr_ptr, ascending with wrap at NUM_MASTERS-1 -> 0.
  - The first asserted master g gets m_gnt[g]=1. At most one grant per cycle.
  - Granted master's addr/wdata/byte_en drive mem_*.
  - mem_write_en = m_we[g]; mem_read_en = ~m_we[g].
- No request: m_gnt=0 and both mem enables 0; mem_addr/wdata/byte_en driven 0 (no stale passthrough).
- Pointer update:
  - On any grant to g, rr_ptr <= g+1, wrapping to 0 when g = NUM_MASTERS-1.
  - No grant: rr_ptr holds.
  - Fairness: a continuously requesting master waits at most NUM_MASTERS-1 cycles.
- Handshake:
  - A master holds req/we/addr/wdata/byte_en stable until it sees m_gnt.
  - The access completes in the grant cycle.
  - A master may re-request back-to-back.
- Read return:
  - rd_pend_q <= m_gnt & ~m_we on every clock.
  - m_rvalid = rd_pend_q; m_rdata = mem_rdata.
  - Writes never raise m_rvalid; m_gnt is the write completion.
- Back-to-back: a read grant in cycle N and a new grant in cycle N+1 overlap legally. m_rvalid in N+1 refers to the cycle-N read.
- Simultaneous all-request: exactly one grant, chosen by rr_ptr.
- Reset mid-operation: an in-flight read is dropped (no m_rvalid after reset), and the pointer returns to 0.
- Size codes pass through untouched. Alignment and sign extension stay in the core and DCCM.

Optional Feature:
- Macro: BRQ_ARB_LOCK_EN.
- Defined:
  - Adds input m_lock (NUM_MASTERS).
  - When master g is granted with m_lock[g]=1, a lock_q register (with lock_owner) is set.
  - While lock_q is set, only lock_owner may be granted; other requests are stalled. The owner must keep m_req asserted.
  - Lock clears on the first cycle the owner is granted with m_lock[g]=0, or when the owner drops m_req.
  - rr_ptr does not advance while locked.
  - This supports atomic read-modify-write.
  - Reset clears lock_q.
- Undefined: no m_lock port; pure round-robin as above.

Test Plan:
- Reset assert mid-read: m0 read at addr 0x10 granted, brq_rst=1 in the next cycle -> m_rvalid=0, rr_ptr=0, all mem enables 0.
- Single master read: m1 req, we=0, addr=0x004, with DCCM[0x004]=0xDEADBEEF -> m_gnt=2'b10 and mem_read_en=1 same cycle; next cycle m_rvalid=2'b10, m_rdata=0xDEADBEEF.
- Write: m0 we=1, addr=0x008, wdata=0x12345678, byte_en=3'b010 -> m_gnt=2'b01, mem_write_en=1, mem_wdata=0x12345678, no m_rvalid; a later read of 0x008 returns 0x12345678.
- Contention, NUM_MASTERS=3, all req held for 6 cycles from reset -> grant sequence m0,m1,m2,m0,m1,m2; max wait 2 cycles.
- Back-to-back reads m0 addr 0x0 then m1 addr 0x4 in consecutive cycles -> m_rvalid 01 then 10, each paired with the correct data.
- With BRQ_ARB_LOCK_EN: m0 locked read then write while m1 requests continuously -> m1 not granted until the cycle after m0's unlocked write grant.
